// File: rtl/slave_mem_pkg.sv
// Shared types and constants for the slave_mem crossbar endpoint.
package slave_mem_pkg;

  // Width of the access-latency wait counter (LATENCY is 0..15).
  localparam int LAT_W = 4;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Transaction sequencing: accept, optional wait, ack strobe, resp strobe.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RESP
  } state_t;

endpackage : slave_mem_pkg

// File: rtl/slave_mem_ram.sv
// Single-port synchronous word array behind slave_mem.
// Read is registered and returns the word stored before a same-edge write.
module slave_mem_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Write port and registered read port share the single index.
  // NOTE: the array has no reset; contents are undefined at power-up so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule : slave_mem_ram

// File: rtl/slave_mem.sv
// Crossbar slave endpoint: word-addressed memory with programmable latency.
// One request at a time over req/ack; one-cycle resp strobe follows ack.
module slave_mem
  import slave_mem_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DEPTH   = 256,
  parameter  int LATENCY = 2,
  localparam int AW      = 32 - $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ack,
  output logic          resp,
  output logic [31:0]   rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  // Counter preload on acceptance; unused when LATENCY is 0 (IDLE jumps to ACK).
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_q, cmd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ram_we;
  logic [31:0]        ram_rdata;

  // Upper address bits only alias onto the array; they carry no function.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr;

  // State register plus counter and request capture registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, latency countdown and capture of the accepted request.
  // NOTE: every signal gets a hold default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cmd_d   = cmd;
          idx_d   = addr[IDX_W-1:0];
          wdata_d = wdata;
          cnt_d   = LAT_LOAD;
          state_d = (LATENCY == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ACK:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes, RAM write enable, and read data presented during the RESP cycle.
  always_comb begin
    ack     = (state_q == ACK);
    resp    = (state_q == RESP);
    ram_we  = (state_q == ACK) && (cmd_q == CMD_WRITE);
    // The RAM word fetched at the end of ACK is shown directly in RESP and then held.
    rdata_d = ((state_q == RESP) && (cmd_q == CMD_READ)) ? ram_rdata : rdata_q;
    rdata   = rdata_d;
  end

  slave_mem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule : slave_mem

// File: tb/tb_slave_mem.sv
// Bench for slave_mem: two instances (LATENCY=2 and LATENCY=0) checked every
// cycle against a timestamp-based transaction model, plus directed scenarios.
module tb_slave_mem;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_v   [2];
  logic          cmd_v   [2];
  logic [AW-1:0] addr_v  [2];
  logic [31:0]   wdata_v [2];
  logic          ack_o   [2];
  logic          resp_o  [2];
  logic [31:0]   rdata_o [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  slave_mem #(.N(4), .DEPTH(256), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .req(req_v[0]), .cmd(cmd_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .ack(ack_o[0]), .resp(resp_o[0]), .rdata(rdata_o[0])
  );

  slave_mem #(.N(4), .DEPTH(256), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .cmd(cmd_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .ack(ack_o[1]), .resp(resp_o[1]), .rdata(rdata_o[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction is described by its age in edges since acceptance:
  // ack while age==LAT, resp while age==LAT+1, idle again after age LAT+2.
  bit          m_busy  [2];
  int          m_age   [2];
  logic        m_cmd   [2];
  logic [7:0]  m_idx   [2];
  logic [31:0] m_wd    [2];
  logic [31:0] m_mem   [2][256];
  bit          m_val   [2][256];
  logic [31:0] m_rdata [2];
  bit          m_known [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]  <= 1'b0;
        m_rdata[i] <= '0;
        m_known[i] <= 1'b1;
      end else if (!m_busy[i]) begin
        if (req_v[i]) begin
          m_busy[i] <= 1'b1;
          m_age[i]  <= 0;
          m_cmd[i]  <= cmd_v[i];
          m_idx[i]  <= addr_v[i][7:0];
          m_wd[i]   <= wdata_v[i];
        end
      end else begin
        m_age[i] <= m_age[i] + 1;
        if (m_age[i] == lat(i)) begin
          if (m_cmd[i]) begin
            m_mem[i][m_idx[i]] <= m_wd[i];
            m_val[i][m_idx[i]] <= 1'b1;
          end else begin
            m_rdata[i] <= m_mem[i][m_idx[i]];
            m_known[i] <= m_val[i][m_idx[i]];
          end
        end
        if (m_age[i] == lat(i) + 1) m_busy[i] <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ack%0d", i), {31'b0, ack_o[i]},
              {31'b0, (m_busy[i] && m_age[i] == lat(i))});
        check($sformatf("resp%0d", i), {31'b0, resp_o[i]},
              {31'b0, (m_busy[i] && m_age[i] == lat(i) + 1)});
        if (m_known[i]) check($sformatf("rdata%0d", i), rdata_o[i], m_rdata[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // One request, held until ack, then sample the resp cycle.
  task automatic txn(input int i, input logic c, input logic [AW-1:0] a,
                     input logic [31:0] d, output logic [31:0] rd);
    int ack_dly;
    @(negedge clk);
    req_v[i] = 1'b1; cmd_v[i] = c; addr_v[i] = a; wdata_v[i] = d;
    ack_dly = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_o[i]) begin
        ack_dly = n;
        break;
      end
    end
    req_v[i] = 1'b0;
    check($sformatf("ack_latency%0d", i), 32'(ack_dly), 32'(lat(i) + 1));
    @(negedge clk);
    check($sformatf("resp_after_ack%0d", i), {31'b0, resp_o[i]}, 32'd1);
    rd = rdata_o[i];
  endtask

  initial begin
    logic [31:0]   rd;
    logic [AW-1:0] a;
    int            acks, resps, dly;

    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; cmd_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ack", {31'b0, ack_o[0]}, 32'd0);
    check("reset_resp", {31'b0, resp_o[0]}, 32'd0);
    check("reset_rdata", rdata_o[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write then read, LATENCY=2.
    txn(0, 1'b1, 30'd5, 32'hDEAD_BEEF, rd);
    txn(0, 1'b0, 30'd5, 32'h0, rd);
    check("raw_deadbeef", rd, 32'hDEAD_BEEF);

    // LATENCY=0 write/read.
    txn(1, 1'b1, 30'd9, 32'hCAFE_0009, rd);
    txn(1, 1'b0, 30'd9, 32'h0, rd);
    check("l0_read", rd, 32'hCAFE_0009);

    // Aliasing: 0x105 and 0x005 share index 5.
    txn(0, 1'b1, 30'h105, 32'h1234_5678, rd);
    txn(0, 1'b0, 30'h005, 32'h0, rd);
    check("alias_read", rd, 32'h1234_5678);

    // Back-to-back on LATENCY=0: req held for 9 edges -> 3 accepts.
    @(negedge clk);
    req_v[1] = 1'b1; cmd_v[1] = 1'b0; addr_v[1] = 30'd9;
    acks = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack_o[1]) acks++;
      if (n == 9) req_v[1] = 1'b0;
    end
    check("b2b_ack_count", 32'(acks), 32'd3);

    // Reset during WAIT of a write: no write, rdata cleared.
    txn(0, 1'b1, 30'd7, 32'h1111_1111, rd);
    @(negedge clk);
    req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 30'd7; wdata_v[0] = 32'hA5A5_A5A5;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", {31'b0, ack_o[0]}, 32'd0);
    check("rst_mid_resp", {31'b0, resp_o[0]}, 32'd0);
    check("rst_mid_rdata", rdata_o[0], 32'd0);
    req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 30'd7, 32'h0, rd);
    check("rst_write_dropped", rd, 32'h1111_1111);

    // req high through reset: nothing accepted, accepted right after release.
    @(negedge clk);
    rst = 1'b1;
    req_v[0] = 1'b1; cmd_v[0] = 1'b0; addr_v[0] = 30'd7;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o[0]) acks++;
    end
    check("no_ack_in_reset", 32'(acks), 32'd0);
    rst = 1'b0;
    dly = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack_o[0] && dly == 0) dly = n;
    end
    req_v[0] = 1'b0;
    check("release_ack_latency", 32'(dly), 32'd3);
    repeat (6) @(negedge clk);

    // req dropped after one cycle in WAIT: exactly one ack and one resp.
    @(negedge clk);
    req_v[0] = 1'b1; cmd_v[0] = 1'b0; addr_v[0] = 30'd7;
    acks = 0; resps = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) req_v[0] = 1'b0;
      if (ack_o[0]) acks++;
      if (resp_o[0]) resps++;
    end
    check("drop_req_acks", 32'(acks), 32'd1);
    check("drop_req_resps", 32'(resps), 32'd1);
    check("drop_req_rdata", rdata_o[0], 32'h1111_1111);

    // Randomized traffic on both instances, checked by the model each cycle.
    for (int n = 0; n < 150; n++) begin
      a = AW'($urandom);
      a[7:4] = 4'h0;
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_slave_mem

// File: doc/slave_mem.md
# slave_mem

Single crossbar slave endpoint: a word-addressed synchronous memory with a programmable access latency, attached downstream of one slave port of the crossbar. It accepts one read or write request at a time over the req/ack handshake and returns a one-cycle resp strobe, with read data on rdata. It is the default target for crossbar system tests and the reference behaviour for later slave peripherals.

## Interface
- N, 4: crossbar port count; sets address width AW = 32-$clog2(N)
- DEPTH, 256: memory words, power of two, 2..65536
- LATENCY, 2: wait cycles between request acceptance and ack, 0..15
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  1  request from crossbar, held until ack seen
- cmd  input  1  1 = write, 0 = read; stable while req high
- addr  input  AW  word address; stable while req high
- wdata  input  32  write data; stable while req high
- ack  output  1  one-cycle acceptance/completion strobe
- resp  output  1  one-cycle response strobe, cycle after ack
- rdata  output  32  read data, valid when resp high after a read

## Operation
- FSM states: IDLE, WAIT, ACK, RESP.
- IDLE: req sampled high -> WAIT with counter loaded to LATENCY-1; if LATENCY=0 -> ACK directly. cmd/addr/wdata captured into internal registers at this edge.
- WAIT: counter decrements each cycle; at 0 -> ACK.
- ACK: ack=1 for exactly one cycle; write performed at end of this cycle (mem[idx] <= captured wdata); read data fetched from mem[idx] -> RESP.
- RESP: resp=1 for exactly one cycle; on reads rdata updated to fetched word in this cycle; -> IDLE.
- Index idx = addr[$clog2(DEPTH)-1:0]; upper address bits ignored (aliasing, no error).
- rdata changes only on read responses; holds value across writes and idle.
- req is only sampled in IDLE; req in WAIT/ACK/RESP ignored. Dropping req before ack (protocol violation) does not abort; transaction completes on captured values.
- Memory contents undefined after power-up; not cleared by rst.

## Timing
- Reset values: ack=0, resp=0, rdata=0, state IDLE, counter 0.
- req high at edge k in IDLE -> ack high in cycle k+LATENCY+1 -> resp high in cycle k+LATENCY+2.
- Read-after-write to same index in consecutive transactions returns the new data.
- Earliest next acceptance: edge following RESP cycle; back-to-back period = LATENCY+3 cycles.
- rst asserted mid-transaction: immediate return to IDLE, ack/resp low; a write whose ACK cycle had not completed is not performed; rdata cleared to 0.
- rst released with req high: request accepted at first edge after release.

## Structure
- Package slave_mem_pkg: state_t enum (IDLE, WAIT, ACK, RESP), CMD_READ=1'b0, CMD_WRITE=1'b1, LAT_W=4 counter width.
- Sub-module slave_mem_ram: single-port synchronous array (DEPTH x 32, we, idx, wdata, rdata), no reset; slave_mem holds FSM, counter, capture registers.

## Test plan
- Reset: assert rst mid-cycle -> ack=0, resp=0, rdata=0 immediately, no req accepted while rst high.
- Write 0xDEADBEEF to addr 5 then read addr 5, LATENCY=2 -> ack 3 cycles after req sample, resp next cycle, rdata=0xDEADBEEF.
- LATENCY=0: read request -> ack in cycle k+1, resp in k+2; back-to-back requests accepted every 3 cycles.
- Aliasing DEPTH=256: write 0x12345678 to addr 0x105, read addr 0x005 -> rdata=0x12345678.
- Reset during WAIT of a write of 0xA5A5A5A5 to addr 7 (previously 0x11111111) -> no ack; subsequent read of addr 7 returns 0x11111111.
- req dropped after one cycle in WAIT -> ack and resp still issued once; no second transaction.
